// File: rtl/tluh_pkg.sv
// Shared TL-UH channel types, opcode/param encodings and burst helpers for
// the error gate and its legality checker.
package tluh_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 3;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_BW  = 8;  // holds 2^(7-SubAW) beats for any 3-bit size

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tluh_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tluh_d_op_e;

  typedef enum logic [2:0] {
    ArithMin  = 3'h0,
    ArithMax  = 3'h1,
    ArithMinu = 3'h2,
    ArithMaxu = 3'h3,
    ArithAdd  = 3'h4
  } tluh_arith_e;

  typedef enum logic [2:0] {
    LogicXor  = 3'h0,
    LogicOr   = 3'h1,
    LogicAnd  = 3'h2,
    LogicSwap = 3'h3
  } tluh_logic_e;

  typedef enum logic [2:0] {
    PrefetchRead  = 3'h0,
    PrefetchWrite = 3'h1
  } tluh_intent_e;

  typedef enum logic [2:0] {
    ErrIdle,
    ErrFwd,
    ErrAbsorb,
    ErrDrain,
    ErrResp
  } tluh_err_state_e;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tluh_d2h_t;

  // Beats in a transfer of 2^size bytes over a 2^sub_aw byte wide bus.
  function automatic logic [TL_BW-1:0] tluh_beats(input logic [TL_SZW-1:0] size,
                                                  input int sub_aw);
    logic [TL_BW-1:0] beats;
    beats = TL_BW'(1);
    if (int'(size) > sub_aw) beats = TL_BW'(1) << (int'(size) - sub_aw);
    return beats;
  endfunction

endpackage

// File: rtl/tluh_err_chk.sv
// Combinational legality check of a TL-UH A-channel first beat: opcode,
// param, size, alignment and lane mask.
module tluh_err_chk
  import tluh_pkg::*;
#(
  parameter int DW      = TL_DW,
  parameter int MaxSize = $clog2(DW/8) + 2
) (
  input  logic [2:0]           opcode_i,
  input  logic [2:0]           param_i,
  input  logic [TL_SZW-1:0]    size_i,
  input  logic [$clog2(DW/8)-1:0] addr_i,
  input  logic [DW/8-1:0]      mask_i,
  output logic                 legal_o
);

  localparam int SubAW = $clog2(DW/8);
  localparam int DBW   = DW / 8;

  logic           op_ok, param_ok, atomic, full_mask, size_ok, align_ok, mask_ok;
  logic [DBW-1:0] active;
  int             size_int, addr_low, low_bits;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    op_ok     = 1'b1;
    param_ok  = 1'b0;
    atomic    = 1'b0;
    full_mask = 1'b1;
    case (opcode_i)
      PutFullData:    param_ok = (param_i == 3'h0);
      PutPartialData: begin
        param_ok  = (param_i == 3'h0);
        full_mask = 1'b0;
      end
      Get:            param_ok = (param_i == 3'h0);
      ArithmeticData: begin
        param_ok = (param_i <= ArithAdd);
        atomic   = 1'b1;
      end
      LogicalData: begin
        param_ok = (param_i <= LogicSwap);
        atomic   = 1'b1;
      end
      Intent: begin
        param_ok  = (param_i <= PrefetchWrite);
        full_mask = 1'b0;
      end
      default: op_ok = 1'b0;
    endcase

    size_int = int'(size_i);
    addr_low = int'(addr_i);
    size_ok  = (size_int <= MaxSize) && (!atomic || size_int <= SubAW);

    // Bursts are beat-aligned, so only the in-beat address bits are checked.
    low_bits = (size_int < SubAW) ? size_int : SubAW;
    align_ok = 1'b1;
    for (int i = 0; i < SubAW; i++) begin
      if (i < low_bits && addr_i[i]) align_ok = 1'b0;
    end

    for (int i = 0; i < DBW; i++) begin
      active[i] = (size_int >= SubAW) ||
                  (i >= addr_low && i < addr_low + (1 << size_int));
    end
    mask_ok = ((mask_i & ~active) == '0) && (!full_mask || mask_i == active);

    legal_o = op_ok && param_ok && size_ok && align_ok && mask_ok;
  end

endmodule

// File: rtl/tluh_err_gate.sv
// TL-UH A-channel error gate: forwards legal requests with zero latency,
// absorbs illegal ones and answers them with a d_error response once drained.
module tluh_err_gate
  import tluh_pkg::*;
#(
  parameter int DW             = TL_DW,
  parameter int MaxSize        = $clog2(DW/8) + 2,
  parameter int MaxOutstanding = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  tluh_h2d_t tl_h_i,
  output tluh_d2h_t tl_h_o,
  output tluh_h2d_t tl_d_o,
  input  tluh_d2h_t tl_d_i,
  output logic      err_o
);

  localparam int SubAW = $clog2(DW/8);
  localparam int CntW  = $clog2(MaxOutstanding + 1);

  tluh_err_state_e   state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [TL_BW-1:0]  a_beat_q, d_beat_q, resp_beat_q;
  tluh_d_op_e        resp_op_q;
  logic [TL_SZW-1:0] resp_size_q;
  logic [TL_AIW-1:0] resp_source_q;

  logic              legal, stall, first_fwd, first_err, a_cont_fire;
  logic              d_fire, d_last, cnt_inc, cnt_dec;
  logic [TL_BW-1:0]  req_beats, d_total, err_beats;
  tluh_d_op_e        err_op;

  tluh_err_chk #(
    .DW      (DW),
    .MaxSize (MaxSize)
  ) u_chk (
    .opcode_i (tl_h_i.a_opcode),
    .param_i  (tl_h_i.a_param),
    .size_i   (tl_h_i.a_size),
    .addr_i   (tl_h_i.a_address[SubAW-1:0]),
    .mask_i   (tl_h_i.a_mask),
    .legal_o  (legal)
  );

  assign stall     = (cnt_q == CntW'(MaxOutstanding));
  assign first_fwd = (state_q == ErrIdle) && tl_h_i.a_valid && legal && !stall &&
                     tl_d_i.a_ready;
  assign first_err = (state_q == ErrIdle) && tl_h_i.a_valid && !legal;
  assign a_cont_fire = tl_h_i.a_valid &&
                       ((state_q == ErrFwd && tl_d_i.a_ready) || state_q == ErrAbsorb);

  // Device responses are tracked per beat so the count drops on the last one.
  assign d_fire  = tl_d_i.d_valid && tl_h_i.d_ready && (state_q != ErrResp);
  assign d_total = (tl_d_i.d_opcode == AccessAckData) ?
                   tluh_beats(tl_d_i.d_size, SubAW) : TL_BW'(1);
  assign d_last  = (d_beat_q == '0) ? (d_total == TL_BW'(1)) : (d_beat_q == TL_BW'(1));
  assign cnt_inc = first_fwd;
  assign cnt_dec = d_fire && d_last;

  always_comb begin
    req_beats = TL_BW'(1);
    err_op    = AccessAck;
    err_beats = TL_BW'(1);
    case (tl_h_i.a_opcode)
      PutFullData, PutPartialData: req_beats = tluh_beats(tl_h_i.a_size, SubAW);
      Get, ArithmeticData, LogicalData: begin
        err_op    = AccessAckData;
        err_beats = tluh_beats(tl_h_i.a_size, SubAW);
      end
      Intent:  err_op = HintAck;
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    err_o           = 1'b0;
    tl_d_o          = tl_h_i;
    tl_d_o.a_valid  = 1'b0;
    tl_d_o.d_ready  = (state_q != ErrResp) && tl_h_i.d_ready;
    tl_h_o          = tl_d_i;
    tl_h_o.a_ready  = 1'b0;
    case (state_q)
      ErrIdle: begin
        if (legal) begin
          tl_d_o.a_valid = tl_h_i.a_valid && !stall;
          tl_h_o.a_ready = tl_d_i.a_ready && !stall;
          if (first_fwd && req_beats > TL_BW'(1)) state_d = ErrFwd;
        end else begin
          tl_h_o.a_ready = 1'b1;
          if (tl_h_i.a_valid) begin
            err_o   = 1'b1;
            state_d = (req_beats > TL_BW'(1)) ? ErrAbsorb : ErrDrain;
          end
        end
      end
      ErrFwd: begin
        tl_d_o.a_valid = tl_h_i.a_valid;
        tl_h_o.a_ready = tl_d_i.a_ready;
        if (a_cont_fire && a_beat_q == TL_BW'(1)) state_d = ErrIdle;
      end
      ErrAbsorb: begin
        tl_h_o.a_ready = 1'b1;
        if (a_cont_fire && a_beat_q == TL_BW'(1)) state_d = ErrDrain;
      end
      ErrDrain: begin
        if (cnt_q == '0) state_d = ErrResp;
      end
      ErrResp: begin
        tl_h_o.d_valid  = 1'b1;
        tl_h_o.d_opcode = resp_op_q;
        tl_h_o.d_param  = '0;
        tl_h_o.d_size   = resp_size_q;
        tl_h_o.d_source = resp_source_q;
        tl_h_o.d_sink   = '0;
        tl_h_o.d_data   = '1;
        tl_h_o.d_error  = 1'b1;
        if (tl_h_i.d_ready && resp_beat_q == TL_BW'(1)) state_d = ErrIdle;
      end
      default: state_d = ErrIdle;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ErrIdle;
      cnt_q         <= '0;
      a_beat_q      <= '0;
      d_beat_q      <= '0;
      resp_beat_q   <= '0;
      resp_op_q     <= AccessAck;
      resp_size_q   <= '0;
      resp_source_q <= '0;
    end else begin
      state_q <= state_d;

      case ({cnt_inc, cnt_dec})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase

      if (first_fwd || first_err) a_beat_q <= req_beats - TL_BW'(1);
      else if (a_cont_fire)       a_beat_q <= a_beat_q - TL_BW'(1);

      if (d_fire) begin
        if (d_last)                d_beat_q <= '0;
        else if (d_beat_q == '0)   d_beat_q <= d_total - TL_BW'(1);
        else                       d_beat_q <= d_beat_q - TL_BW'(1);
      end

      if (first_err) begin
        resp_op_q     <= err_op;
        resp_size_q   <= tl_h_i.a_size;
        resp_source_q <= tl_h_i.a_source;
        resp_beat_q   <= err_beats;
      end else if (state_q == ErrResp && tl_h_i.d_ready) begin
        resp_beat_q <= resp_beat_q - TL_BW'(1);
      end
    end
  end

endmodule
